// File: rtl/dsp_control_if.sv
// Control bus between the DSP program sequencer and its datapath /
// instruction memory. The master side is the sequencer.
interface dsp_control_if #(
    parameter int PC_W    = 12,
    parameter int DADDR_W = 7
);
    logic [15:0]        instr;
    logic               acc_zero;
    logic               acc_neg;
    logic [PC_W-1:0]    pc;
    logic [DADDR_W-1:0] mem_addr;
    logic               mem_we;
    logic               t_en;
    logic               p_en;
    logic               acc_en;
    logic               mult_in_sel;
    logic [3:0]         alu_shift;
    logic [1:0]         alu_in_sel;
    logic [2:0]         alu_op;
    logic [2:0]         acc_in_sel;
    logic [PC_W-1:0]    stack_top;
    logic               illegal;

    modport master (
        input  instr, acc_zero, acc_neg,
        output pc, mem_addr, mem_we, t_en, p_en, acc_en, mult_in_sel,
               alu_shift, alu_in_sel, alu_op, acc_in_sel, stack_top, illegal
    );

    modport slave (
        output instr, acc_zero, acc_neg,
        input  pc, mem_addr, mem_we, t_en, p_en, acc_en, mult_in_sel,
               alu_shift, alu_in_sel, alu_op, acc_in_sel, stack_top, illegal
    );
endinterface

// File: rtl/dsp_control.sv
// Instruction decoder and program sequencer for a TMS32010-subset DSP.
// Decodes the word at pc combinationally, owns the PC, the two-word
// branch/call sequence and a small hardware return stack.
module dsp_control #(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 12,
    parameter int DADDR_W     = 7
) (
    input  logic          clk,
    input  logic          reset,
    dsp_control_if.master bus
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [1:0] AIN_SHIFT = 2'd0;
    localparam logic [1:0] AIN_P     = 2'd1;
    localparam logic [2:0] ACC_ALU   = 3'd0;
    localparam logic [2:0] ACC_SHIFT = 3'd1;
    localparam logic [2:0] ACC_P     = 3'd2;
    localparam logic [2:0] ACC_K8    = 3'd4;
    localparam logic [2:0] ACC_ZERO  = 3'd6;

    typedef enum logic {RUN = 1'b0, BR2 = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 taken_q, taken_d;
    logic                 call_q, call_d;
    logic [PC_W-1:0]      stk_q [STACK_DEPTH];
    logic [CNT_W-1:0]     cnt_q;

    logic                 mem_we, t_en, p_en, acc_en, mult_in_sel, illegal;
    logic [3:0]           alu_shift;
    logic [1:0]           alu_in_sel;
    logic [2:0]           alu_op, acc_in_sel;
    logic                 is_branch, br_cond, br_call, is_ret;
    logic                 push, pop;
    logic [PC_W-1:0]      pc_inc, stack_top;
    logic                 stk_empty, stk_full;

    assign pc_inc    = pc_q + PC_W'(1);
    assign stk_empty = (cnt_q == '0);
    assign stk_full  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign stack_top = stk_empty ? '0 : stk_q[0];

    // Instruction decode: datapath controls for the word at pc (RUN only).
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        mem_we      = 1'b0;
        t_en        = 1'b0;
        p_en        = 1'b0;
        acc_en      = 1'b0;
        mult_in_sel = 1'b0;
        alu_shift   = 4'd0;
        alu_in_sel  = AIN_SHIFT;
        alu_op      = ALU_ADD;
        acc_in_sel  = ACC_ALU;
        illegal     = 1'b0;
        is_branch   = 1'b0;
        br_cond     = 1'b0;
        br_call     = 1'b0;
        is_ret      = 1'b0;
        if (reset && state_q == RUN) begin
            case (bus.instr[15:12])
                4'h0, 4'h1, 4'h2: begin
                    if (bus.instr[7]) begin
                        illegal = 1'b1;
                    end else begin
                        alu_shift = bus.instr[11:8];
                        acc_en    = 1'b1;
                        if (bus.instr[13]) acc_in_sel = ACC_SHIFT;
                        else if (bus.instr[12]) alu_op = ALU_SUB;
                    end
                end
                4'h5: begin
                    if (bus.instr[11:7] == 5'b0) mem_we = 1'b1;
                    else illegal = 1'b1;
                end
                4'h6: begin
                    if (!bus.instr[7] && bus.instr[11:8] == 4'hA) begin
                        t_en = 1'b1;
                    end else if (!bus.instr[7] && bus.instr[11:8] == 4'hD) begin
                        p_en = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                4'h7: begin
                    if (bus.instr[11:8] == 4'hE) begin
                        acc_en     = 1'b1;
                        acc_in_sel = ACC_K8;
                    end else begin
                        case (bus.instr[11:0])
                            12'hF80: ;
                            12'hF89: begin acc_en = 1'b1; acc_in_sel = ACC_ZERO; end
                            12'hF8D: is_ret = 1'b1;
                            12'hF8E: begin acc_en = 1'b1; acc_in_sel = ACC_P; end
                            12'hF8F: begin acc_en = 1'b1; alu_in_sel = AIN_P; end
                            12'hF90: begin
                                acc_en     = 1'b1;
                                alu_in_sel = AIN_P;
                                alu_op     = ALU_SUB;
                            end
                            default: illegal = 1'b1;
                        endcase
                    end
                end
                4'h8, 4'h9: begin
                    p_en        = 1'b1;
                    mult_in_sel = 1'b1;
                end
                4'hF: begin
                    is_branch = 1'b1;
                    case (bus.instr[11:0])
                        12'h900: br_cond = 1'b1;
                        12'h800: begin br_cond = 1'b1; br_call = 1'b1; end
                        12'hF00: br_cond = bus.acc_zero;
                        12'hE00: br_cond = !bus.acc_zero;
                        12'hA00: br_cond = bus.acc_neg;
                        12'hD00: br_cond = !bus.acc_neg;
                        default: begin is_branch = 1'b0; illegal = 1'b1; end
                    endcase
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Sequencing: next PC, branch second word, stack push/pop requests.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_inc;
        taken_d = taken_q;
        call_d  = call_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == RUN) begin
            if (is_branch) begin
                state_d = BR2;
                taken_d = br_cond;
                call_d  = br_call;
            end else if (is_ret) begin
                pc_d = stack_top;
                pop  = !stk_empty;
            end
        end else begin
            state_d = RUN;
            push    = call_q;
            if (taken_q) pc_d = bus.instr[PC_W-1:0];
        end
    end

    // State, PC and return stack registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            taken_q <= 1'b0;
            call_q  <= 1'b0;
            cnt_q   <= '0;
            // NOTE: the stack is a handful of flops, so clearing it costs little and makes stack_top defined.
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            call_q  <= call_d;
            if (push) begin
                stk_q[0] <= pc_inc;
                for (int i = 1; i < STACK_DEPTH; i++) stk_q[i] <= stk_q[i-1];
                if (!stk_full) cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop) begin
                for (int i = 0; i < STACK_DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
                stk_q[STACK_DEPTH-1] <= '0;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.mem_addr    = bus.instr[DADDR_W-1:0];
    assign bus.mem_we      = mem_we;
    assign bus.t_en        = t_en;
    assign bus.p_en        = p_en;
    assign bus.acc_en      = acc_en;
    assign bus.mult_in_sel = mult_in_sel;
    assign bus.alu_shift   = alu_shift;
    assign bus.alu_in_sel  = alu_in_sel;
    assign bus.alu_op      = alu_op;
    assign bus.acc_in_sel  = acc_in_sel;
    assign bus.stack_top   = stack_top;
    assign bus.illegal     = illegal;
endmodule

// File: doc/dsp_control.md
Name: dsp_control

Overview:
- Instruction decoder and program sequencer for the TMS32010-subset DSP datapath.
- Each cycle it consumes the 16-bit instruction word fetched at its own PC. It drives every datapath control: register enables, mux selects, shifter amount, ALU command and data-memory write.
- Owns the 12-bit PC, two-word branch/call sequencing and a 4-deep hardware return stack.

Parameters:
- STACK_DEPTH, 4, number of return-stack entries.
- PC_W, 12, PC and stack entry width.
- DADDR_W, 7, direct data-memory address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low; clears PC, state, stack.
- instr  in  16  instruction word at current pc, valid same cycle.
- acc_zero  in  1  accumulator == 0.
- acc_neg  in  1  accumulator bit 31.
- pc  out  PC_W  program address to instruction memory.
- mem_addr  out  DADDR_W  data-memory address (instr[6:0]).
- mem_we  out  1  data-memory write (SACL).
- t_en  out  1  load T register from data bus.
- p_en  out  1  load P register from multiplier.
- acc_en  out  1  load accumulator.
- mult_in_sel  out  1  0 = data bus, 1 = sign-extended 13-bit constant.
- alu_shift  out  4  left-shift amount applied to data bus.
- alu_in_sel  out  2  0 = shifted data, 1 = P, 2 = data bus sign-extended.
- alu_op  out  3  0 = ADD, 1 = SUB (other codes unused).
- acc_in_sel  out  3  0 = ALU, 1 = shifted data, 2 = P, 4 = instr[7:0] sign-extended, 5 = stack top, 6 = constant zero.
- stack_top  out  PC_W  current top-of-stack entry.
- illegal  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- States: RUN, BR2. Reset state is RUN.
- Reset values: pc = 0, stack empty, stack_top = 0, illegal = 0, and all enables (mem_we, t_en, p_en, acc_en) = 0.
- Selects are don't-care whenever their enable is 0; drive them to 0.
- RUN: decode instr combinationally. Outputs are valid the same cycle, register writes occur at the next edge, and pc <= pc+1 unless stated otherwise.
- Decode rules (instr[7] = 1, indirect addressing, is illegal for memory ops):
  - ADD 0x0SAA: alu_shift = S, alu_in_sel 0, alu_op ADD, acc_in_sel 0, acc_en.
  - SUB 0x1SAA: as ADD with alu_op SUB.
  - LAC 0x2SAA: alu_shift = S, acc_in_sel 1, acc_en.
  - SACL 0x50AA: mem_we.
  - LT 0x6AAA: t_en.
  - MPY 0x6DAA: mult_in_sel 0, p_en.
  - MPYK 100x_xxxx_xxxx_xxxx: mult_in_sel 1, p_en.
  - LACK 0x7Ekk: acc_in_sel 4, acc_en.
  - ZAC 0x7F89: acc_in_sel 6, acc_en.
  - PAC 0x7F8E: acc_in_sel 2, acc_en.
  - APAC 0x7F8F: alu_in_sel 1, ADD, acc_in_sel 0, acc_en.
  - SPAC 0x7F90: as APAC with SUB.
  - NOP 0x7F80: no enables.
  - RET 0x7F8D: pc <= stack_top, pop.
- Branches are two-word: B 0xF900, CALL 0xF800, BZ 0xFF00, BNZ 0xFE00, BLZ 0xFA00, BGEZ 0xFD00.
  - Opcode cycle: all enables 0. The condition is evaluated from acc_zero/acc_neg in this cycle and registered as taken. pc <= pc+1, state <= BR2.
  - BR2 cycle: instr is the target word and all enables are 0.
  - If taken, pc <= instr[11:0]; otherwise pc <= pc+1. CALL is always taken and pushes pc+1 (the address after the target word).
  - state <= RUN.
- Any other opcode: behaves as NOP, illegal = 1 for that cycle, pc+1.
- PC wraps 0xFFF -> 0x000.
- Stack overflow: a push when full discards the oldest entry, and the new entry becomes the top.
- Stack underflow: RET when empty loads pc <= 0 and the stack stays empty.
- reset = 0 in any state, including BR2, overrides everything at the next edge.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with instr = 0x0000 -> pc = 0, all enables 0. After release, ADD 0x0305 gives alu_shift = 3, mem_addr = 5, acc_en = 1, alu_op = 0, acc_in_sel = 0, and pc increments to 1.
- Multiply sequence: LT 0x6A10, MPY 0x6D11, PAC 0x7F8E -> t_en, then p_en with mult_in_sel = 0, then acc_en with acc_in_sel = 2 on three consecutive cycles.
- Branches: BZ 0xFF00 at pc = 0x020 with target word 0x055.
  - acc_zero = 1 -> all enables 0 for 2 cycles, then pc = 0x055.
  - Repeat with acc_zero = 0 -> pc = 0x022.
- Call/return: CALL 0xF800 at pc = 0x010 with target word 0x100 -> pc = 0x100 and stack_top = 0x012. A RET at 0x100 -> pc = 0x012 and the stack is empty.
- Stack limits: 5 nested CALLs from addresses A0..A4 -> 4 RETs return to A4+2, A3+2, A2+2, A1+2; a 5th RET gives pc = 0.
- Illegal and reset: instr = 0xC000 -> illegal = 1 for one cycle, no enables, pc+1. Asserting reset during BR2 -> next cycle pc = 0, state RUN.
